// File: rtl/simmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simmem_pkg
//  Brief    : Shared types and default constants for the simulated-memory
//             release scheduler (timer state encoding, parameter defaults).
//  Revision : 1.0 - initial release
// ============================================================================
package simmem_pkg;

    localparam int DEFAULT_ID_WIDTH     = 4;
    localparam int DEFAULT_DELAY_WIDTH  = 8;
    localparam int DEFAULT_CREDIT_WIDTH = 3;

    // Per-ID timer: IDLE accepts a new schedule, COUNT is counting down.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } timer_state_e;

endpackage
`default_nettype wire

// File: rtl/simmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : simmem_rr_arbiter
//  Brief    : Round-robin pick among requesting IDs. The search starts at
//             ptr and walks upward, wrapping from the last ID back to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module simmem_rr_arbiter #(
    parameter int IDWidth = 4
) (
    input  logic [2**IDWidth-1:0] req,
    input  logic [IDWidth-1:0]    ptr,
    output logic [2**IDWidth-1:0] gnt,
    output logic                  valid
);
    localparam int NumIds = 2**IDWidth;

    logic [IDWidth-1:0] idx;
    logic               found;

    // First requester at or after ptr; the IDWidth-bit add wraps for free.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NumIds; k++) begin
            idx = ptr + IDWidth'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = found;
    end

endmodule
`default_nettype wire

// File: rtl/simmem_release_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : simmem_release_scheduler
//  Brief    : Per-ID delay timers feeding per-ID release credits, with a
//             round-robin registered one-hot release enable towards the
//             linked-list bank. A grant is held until the bank reports the
//             matching release, then one idle cycle precedes the next grant.
//  Revision : 1.0 - initial release
// ============================================================================
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int IDWidth     = DEFAULT_ID_WIDTH,
    parameter int DelayWidth  = DEFAULT_DELAY_WIDTH,
    parameter int CreditWidth = DEFAULT_CREDIT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sched_valid_i,
    output logic                  sched_ready_o,
    input  logic [IDWidth-1:0]    sched_id_i,
    input  logic [DelayWidth-1:0] sched_delay_i,
    output logic [2**IDWidth-1:0] release_en_o,
    input  logic                  released_i,
    input  logic [IDWidth-1:0]    released_id_i,
    output logic                  illegal_release_o
);
    localparam int                     NumIds    = 2**IDWidth;
    localparam logic [CreditWidth-1:0] CreditOne = CreditWidth'(1);
    localparam logic [DelayWidth-1:0]  DelayOne  = DelayWidth'(1);
    localparam logic [IDWidth-1:0]     IdOne     = IDWidth'(1);
    localparam logic [NumIds-1:0]      OneHotLsb = NumIds'(1);

    logic                sched_fire;
    logic [NumIds-1:0]   id_idle;
    logic [NumIds-1:0]   credit_full;
    logic [NumIds-1:0]   has_credit;
    logic [NumIds-1:0]   expire_vec;
    logic [NumIds-1:0]   arb_req;
    logic [NumIds-1:0]   arb_gnt;
    logic [NumIds-1:0]   released_oh;
    logic                arb_valid;
    logic                grant_active;
    logic                release_match;
    logic [IDWidth-1:0]  grant_id;
    logic [IDWidth-1:0]  rr_ptr;

    // Ready only looks at the addressed ID, never at valid.
    assign sched_ready_o = id_idle[sched_id_i] && !credit_full[sched_id_i];
    assign sched_fire    = sched_valid_i && sched_ready_o;

    // A release matches only when it names the ID currently granted.
    assign grant_active  = |release_en_o;
    assign released_oh   = OneHotLsb << released_id_i;
    assign release_match = released_i && |(release_en_o & released_oh);

    // An expiring timer requests in the same cycle its credit is booked, so
    // the registered enable appears delay+2 cycles after the handshake.
    assign arb_req = has_credit | expire_vec;

    for (genvar g = 0; g < NumIds; g++) begin : g_id
        timer_state_e          state_q;
        timer_state_e          state_d;
        logic [DelayWidth-1:0] timer_q;
        logic [DelayWidth-1:0] timer_d;
        logic [CreditWidth-1:0] credit_q;
        logic                  load;
        logic                  expire;
        logic                  idle;
        logic                  dec;

        assign load = sched_fire && (sched_id_i == IDWidth'(g));
        assign dec  = release_match && release_en_o[g];

        // Timer state and countdown registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
            end
        end

        // Load on handshake, count down to zero, then return to IDLE.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d = COUNT;
                        timer_d = sched_delay_i;
                    end
                end
                COUNT: begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - DelayOne;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // Timer outputs: expiry strobe and idle flag.
        always_comb begin
            expire = (state_q == COUNT) && (timer_q == '0);
            idle   = (state_q == IDLE);
        end

        // Credit counter: +1 on expiry, -1 on matching release, both cancel.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                credit_q <= '0;
            end else if (expire && !dec) begin
                credit_q <= credit_q + CreditOne;
            end else if (dec && !expire) begin
                credit_q <= credit_q - CreditOne;
            end
        end

        assign expire_vec[g]  = expire;
        assign id_idle[g]     = idle;
        assign has_credit[g]  = (credit_q != '0);
        assign credit_full[g] = (credit_q == '1);
    end

    simmem_rr_arbiter #(
        .IDWidth (IDWidth)
    ) u_arbiter (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // Binary index of the held one-hot grant.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NumIds; i++) begin
            if (release_en_o[i]) begin
                grant_id = IDWidth'(i);
            end
        end
    end

    // Grant register: clears on matching release, loads only when idle,
    // which yields exactly one empty cycle between consecutive grants.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            release_en_o      <= '0;
            rr_ptr            <= '0;
            illegal_release_o <= 1'b0;
        end else begin
            illegal_release_o <= released_i && !release_match;
            if (release_match) begin
                release_en_o <= '0;
                rr_ptr       <= grant_id + IdOne;
            end else if (!grant_active && arb_valid) begin
                release_en_o <= arb_gnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simmem_release_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simmem_release_scheduler
//  Brief    : Self-checking bench: vector table, directed corner sequences and
//             random traffic against an event-time reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simmem_release_scheduler;

    localparam int NIDS = 16;
    localparam int CMAX = 7;

    logic        clk_i         = 1'b0;
    logic        rst_ni        = 1'b0;
    logic        sched_valid_i = 1'b0;
    logic [3:0]  sched_id_i    = 4'h0;
    logic [7:0]  sched_delay_i = 8'h00;
    logic        released_i    = 1'b0;
    logic [3:0]  released_id_i = 4'h0;
    logic        sched_ready_o;
    logic [15:0] release_en_o;
    logic        illegal_release_o;

    simmem_release_scheduler dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .sched_valid_i     (sched_valid_i),
        .sched_ready_o     (sched_ready_o),
        .sched_id_i        (sched_id_i),
        .sched_delay_i     (sched_delay_i),
        .release_en_o      (release_en_o),
        .released_i        (released_i),
        .released_id_i     (released_id_i),
        .illegal_release_o (illegal_release_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: absolute event times instead of countdowns.
    int m_credit [NIDS];
    int m_avail  [NIDS];   // cycle in which the expiry becomes arbitrable
    int m_free   [NIDS];   // first cycle the ID may be scheduled again
    bit m_pend   [NIDS];
    int m_grant;
    int m_rr;
    bit m_ill;
    int cyc;

    logic        last_ready;
    logic [15:0] last_en;
    logic        last_ill;
    logic [15:0] one16 = 16'h0001;

    typedef struct {
        bit          v;
        int          id;
        int          d;
        bit          r;
        int          rid;
        bit          e_ready;
        logic [15:0] e_en;
        bit          e_ill;
    } vec_t;

    vec_t tbl [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NIDS; i++) begin
            m_credit[i] = 0;
            m_avail[i]  = 0;
            m_free[i]   = 0;
            m_pend[i]   = 1'b0;
        end
        m_grant = -1;
        m_rr    = 0;
        m_ill   = 1'b0;
        cyc     = 0;
    endfunction

    function automatic bit model_empty();
        bit e;
        e = (m_grant < 0);
        for (int i = 0; i < NIDS; i++) begin
            if (m_credit[i] != 0 || m_pend[i]) e = 1'b0;
        end
        return e;
    endfunction

    function automatic void model_step(input bit hs, input int id, input int d,
                                       input bit r, input int rid);
        bit match;
        bit found;
        int pick;
        match = r && (m_grant >= 0) && (m_grant == rid);
        m_ill = r && !match;
        if (match) begin
            m_credit[m_grant]--;
            m_rr    = (m_grant + 1) % NIDS;
            m_grant = -1;
        end else if (m_grant < 0) begin
            found = 1'b0;
            for (int k = 0; k < NIDS; k++) begin
                pick = (m_rr + k) % NIDS;
                if (!found && (m_credit[pick] > 0 || (m_pend[pick] && m_avail[pick] == cyc))) begin
                    m_grant = pick;
                    found   = 1'b1;
                end
            end
        end
        for (int i = 0; i < NIDS; i++) begin
            if (m_pend[i] && m_avail[i] == cyc) begin
                m_credit[i]++;
                m_pend[i] = 1'b0;
            end
        end
        if (hs) begin
            m_pend[id]  = 1'b1;
            m_avail[id] = cyc + d + 1;
            m_free[id]  = cyc + d + 2;
        end
        cyc++;
    endfunction

    // One clock cycle: drive, sample at negedge, compare to model, advance.
    task automatic cycle_io(input bit v, input int id, input int d, input bit r, input int rid);
        bit          ready_m;
        logic [15:0] en_m;
        sched_valid_i = v;
        sched_id_i    = 4'(id);
        sched_delay_i = 8'(d);
        released_i    = r;
        released_id_i = 4'(rid);
        @(negedge clk_i);
        ready_m = (cyc >= m_free[id]) && (m_credit[id] < CMAX);
        en_m    = (m_grant >= 0) ? (one16 << m_grant) : 16'h0000;
        last_ready = sched_ready_o;
        last_en    = release_en_o;
        last_ill   = illegal_release_o;
        check("model_ready",   32'(last_ready), 32'(ready_m));
        check("model_release", 32'(last_en),    32'(en_m));
        check("model_illegal", 32'(last_ill),   32'(m_ill));
        model_step(v && ready_m, id, d, r, rid);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        while (left > 0 && !model_empty()) begin
            if (m_grant >= 0) cycle_io(1'b0, 0, 0, 1'b1, m_grant);
            else              cycle_io(1'b0, 0, 0, 1'b0, 0);
            left--;
        end
        n_checks++;
        if (!model_empty()) begin
            n_fail++;
            $display("FAIL drain_timeout at cycle %0d: got pending work, expected idle", cyc);
        end
    endtask

    function automatic void set_row(input int i, input bit v, input int id, input int d,
                                    input bit r, input int rid, input bit er,
                                    input logic [15:0] ee, input bit ei);
        tbl[i].v       = v;
        tbl[i].id      = id;
        tbl[i].d       = d;
        tbl[i].r       = r;
        tbl[i].rid     = rid;
        tbl[i].e_ready = er;
        tbl[i].e_en    = ee;
        tbl[i].e_ill   = ei;
    endfunction

    initial begin : main
        int          order [3];
        int          prev;
        logic [15:0] seen;
        bit          rv;
        int          rid;
        int          rsel;

        // Table: ID 3, delay 5 at cycle 10 -> enable from 17, release, then
        // a stray release with no grant.
        for (int i = 0; i < 10; i++) set_row(i, 1'b0, 3, 0, 1'b0, 0, 1'b1, 16'h0000, 1'b0);
        set_row(10, 1'b1, 3, 5, 1'b0, 0, 1'b1, 16'h0000, 1'b0);
        for (int i = 11; i < 17; i++) set_row(i, 1'b0, 3, 0, 1'b0, 0, 1'b0, 16'h0000, 1'b0);
        set_row(17, 1'b0, 3, 0, 1'b0, 0, 1'b1, 16'h0008, 1'b0);
        set_row(18, 1'b0, 3, 0, 1'b0, 0, 1'b1, 16'h0008, 1'b0);
        set_row(19, 1'b0, 3, 0, 1'b1, 3, 1'b1, 16'h0008, 1'b0);
        set_row(20, 1'b0, 3, 0, 1'b0, 0, 1'b1, 16'h0000, 1'b0);
        set_row(21, 1'b0, 3, 0, 1'b1, 9, 1'b1, 16'h0000, 1'b0);
        set_row(22, 1'b0, 3, 0, 1'b0, 0, 1'b1, 16'h0000, 1'b1);

        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ready",   32'(sched_ready_o),     32'd1);
        check("reset_release", 32'(release_en_o),      32'd0);
        check("reset_illegal", 32'(illegal_release_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();

        for (int i = 0; i < 23; i++) begin
            cycle_io(tbl[i].v, tbl[i].id, tbl[i].d, tbl[i].r, tbl[i].rid);
            check("tbl_ready",   32'(last_ready), 32'(tbl[i].e_ready));
            check("tbl_release", 32'(last_en),    32'(tbl[i].e_en));
            check("tbl_illegal", 32'(last_ill),   32'(tbl[i].e_ill));
        end

        // Round robin: credits on 1, 2, 5 with pointer at 2 -> 2, 5, 1.
        cycle_io(1'b1, 1, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        cycle_io(1'b1, 2, 0, 1'b0, 0);
        check("rr_first_grant", 32'(last_en), 32'h0002);
        cycle_io(1'b1, 5, 0, 1'b0, 0);
        cycle_io(1'b1, 1, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        order[0] = 2; order[1] = 5; order[2] = 1;
        prev = 1;
        for (int k = 0; k < 3; k++) begin
            cycle_io(1'b0, 0, 0, 1'b1, prev);
            check("rr_held", 32'(last_en), 32'(one16 << prev));
            cycle_io(1'b0, 0, 0, 1'b0, 0);
            check("rr_gap", 32'(last_en), 32'h0000);
            cycle_io(1'b0, 0, 0, 1'b0, 0);
            check("rr_order", 32'(last_en), 32'(one16 << order[k]));
            prev = order[k];
        end
        cycle_io(1'b0, 0, 0, 1'b1, prev);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        check("rr_final_idle", 32'(last_en), 32'h0000);

        // Ready is per ID: 4 counting, 6 free, within one cycle.
        cycle_io(1'b1, 4, 9, 1'b0, 0);
        sched_valid_i = 1'b0;
        sched_id_i    = 4'd4;
        #1;
        check("ready_busy_id4", 32'(sched_ready_o), 32'd0);
        sched_id_i = 4'd6;
        #1;
        check("ready_free_id6", 32'(sched_ready_o), 32'd1);
        drain(60);

        // Credit saturation on ID 7.
        for (int k = 0; k < 7; k++) begin
            cycle_io(1'b1, 7, 0, 1'b0, 0);
            cycle_io(1'b0, 7, 0, 1'b0, 0);
        end
        cycle_io(1'b0, 7, 0, 1'b0, 0);
        check("ready_credit_full", 32'(last_ready), 32'd0);
        check("grant_id7", 32'(last_en), 32'h0080);
        cycle_io(1'b0, 7, 0, 1'b1, 7);
        cycle_io(1'b0, 7, 0, 1'b0, 0);
        check("ready_after_release", 32'(last_ready), 32'd1);
        drain(60);

        // Mismatched release while ID 2 is granted.
        cycle_io(1'b1, 2, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        check("illegal_pre_grant", 32'(last_en), 32'h0004);
        cycle_io(1'b0, 0, 0, 1'b1, 9);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        check("illegal_pulse", 32'(last_ill), 32'd1);
        check("illegal_grant_kept", 32'(last_en), 32'h0004);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        check("illegal_pulse_end", 32'(last_ill), 32'd0);
        cycle_io(1'b0, 0, 0, 1'b1, 2);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        check("illegal_no_extra_grant", 32'(last_en), 32'h0000);

        // Asynchronous reset mid-count and mid-grant.
        cycle_io(1'b1, 0, 20, 1'b0, 0);
        cycle_io(1'b1, 5, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        cycle_io(1'b0, 0, 0, 1'b0, 0);
        check("rst_pre_grant", 32'(last_en), 32'h0020);
        cycle_io(1'b0, 0, 0, 1'b1, 3);
        check("rst_pre_illegal", 32'(illegal_release_o), 32'd1);
        sched_id_i = 4'd0;
        released_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_release", 32'(release_en_o),      32'd0);
        check("rst_async_illegal", 32'(illegal_release_o), 32'd0);
        check("rst_async_ready",   32'(sched_ready_o),     32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
        seen = 16'h0000;
        for (int k = 0; k < 30; k++) begin
            cycle_io(1'b0, k % NIDS, 0, 1'b0, 0);
            seen = seen | last_en;
        end
        check("rst_no_release_after", 32'(seen), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rv   = 1'b0;
            rid  = 0;
            rsel = int'($urandom_range(0, 9));
            if (m_grant >= 0 && rsel < 6) begin
                rv  = 1'b1;
                rid = m_grant;
            end else if (rsel == 9) begin
                rv  = 1'b1;
                rid = int'($urandom_range(0, 15));
            end
            cycle_io(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 6)), rv, rid);
        end
        drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
